inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 169 ++++++++++++++++
 tb/tb_inst_fetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues imem requests and feeds the IF/ID register through a one-entry skid buffer.
// Latency: the response is registered into IF/ID on the edge it arrives; up to 1 instruction per cycle.
// Backpressure: id_stall holds IF/ID, a second word parks in the skid buffer, and fetch pauses until it drains.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req / imem_addr    request to instruction memory, held until imem_rvalid
//   imem_rvalid / imem_rdata response for the outstanding request
//   redirect_valid / redirect_pc  branch/jump redirect from execute (target word-aligned here)
//   id_stall                decode cannot take id_inst this cycle
//   id_valid / id_inst / id_pc / id_pc_plus4  IF/ID register contents
//   perf_fetch_cnt / perf_drop_cnt  optional counters, present only with FETCH_PERF_CNT_EN defined
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // DROP: a request is still outstanding but its answer belongs to a
    // path that a redirect has abandoned.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        skid_valid, skid_valid_nxt;
    logic [31:0] skid_inst, skid_inst_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_inst_nxt, id_pc_nxt;
    logic        id_free;

    assign id_free     = !id_valid || !id_stall;
    assign imem_req    = (state == WAIT) || (state == DROP);
    assign imem_addr   = pc;
    assign id_pc_plus4 = id_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            skid_valid <= 1'b0;
            skid_inst  <= NOP;
            skid_pc    <= 32'h0;
            id_valid   <= 1'b0;
            id_inst    <= NOP;
            id_pc      <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_inst  <= skid_inst_nxt;
            skid_pc    <= skid_pc_nxt;
            id_valid   <= id_valid_nxt;
            id_inst    <= id_inst_nxt;
            id_pc      <= id_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_valid_nxt = skid_valid;
        skid_inst_nxt  = skid_inst;
        skid_pc_nxt    = skid_pc;
        id_valid_nxt   = id_valid;
        id_inst_nxt    = id_inst;
        id_pc_nxt      = id_pc;

        if (redirect_valid) begin
            // Redirect wins over everything: flush both holding registers.
            // If the pending answer arrives now it is simply thrown away and
            // the next request can go straight out to the new target.
            pc_nxt         = {redirect_pc[31:2], 2'b00};
            id_valid_nxt   = 1'b0;
            skid_valid_nxt = 1'b0;
            unique case (state)
                IDLE:       state_nxt = IDLE;
                WAIT, DROP: state_nxt = imem_rvalid ? WAIT : DROP;
                default:    state_nxt = IDLE;
            endcase
        end else begin
            // Decode takes IF/ID this cycle: refill from the skid entry or empty it.
            if (id_valid && !id_stall) begin
                if (skid_valid) begin
                    id_inst_nxt    = skid_inst;
                    id_pc_nxt      = skid_pc;
                    skid_valid_nxt = 1'b0;
                end else begin
                    id_valid_nxt = 1'b0;
                end
            end

            unique case (state)
                IDLE: begin
                    state_nxt = skid_valid_nxt ? IDLE : WAIT;
                end
                WAIT: begin
                    // The skid buffer is always empty here: it is only filled
                    // on a response, which sends us to IDLE until it drains.
                    if (imem_rvalid) begin
                        pc_nxt = pc + 32'd4;
                        if (id_free) begin
                            id_valid_nxt = 1'b1;
                            id_inst_nxt  = imem_rdata;
                            id_pc_nxt    = pc;
                        end else begin
                            skid_valid_nxt = 1'b1;
                            skid_inst_nxt  = imem_rdata;
                            skid_pc_nxt    = pc;
                        end
                        state_nxt = skid_valid_nxt ? IDLE : WAIT;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_nxt = WAIT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_load;
    logic drop_evt;

    // One count per instruction entering IF/ID, whether from memory or the skid entry.
    assign fetch_load = !redirect_valid &&
                        (((state == WAIT) && imem_rvalid && id_free) ||
                         (id_valid && !id_stall && skid_valid));
    assign drop_evt   = imem_rvalid &&
                        ((state == DROP) || ((state == WAIT) && redirect_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0;
            perf_drop_cnt  <= 32'h0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {31'd0, fetch_load};
            perf_drop_cnt  <= perf_drop_cnt + {31'd0, drop_evt};
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a small instruction memory with programmable
// latency and response budget, a scoreboard queue of expected IF/ID deliveries,
// and one task per scenario.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mem_lat  = 0;
    int mem_left = 0;
    int mem_cnt  = 0;
    logic [31:0] sb_pc[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hA5A5_0033;
    endfunction

    // One clock cycle: drive the memory response for this cycle, account for
    // any IF/ID delivery decode takes, then advance to #1 after the edge.
    task automatic tick();
        logic [31:0] exp;
        if (imem_req && mem_left > 0) begin
            if (mem_cnt >= mem_lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = inst_of(imem_addr);
                mem_cnt     = 0;
                mem_left    = mem_left - 1;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
                mem_cnt     = mem_cnt + 1;
            end
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        if (id_valid && !id_stall && !redirect_valid) begin
            checks++;
            if (sb_pc.size() == 0) begin
                errors++;
                $display("FAIL deliver_extra: got pc %h inst %h, expected no delivery", id_pc, id_inst);
            end else begin
                exp = sb_pc.pop_front();
                if (id_pc !== exp || id_inst !== inst_of(exp) || id_pc_plus4 !== exp + 32'd4) begin
                    errors++;
                    $display("FAIL deliver: got pc %h inst %h pc4 %h, expected pc %h inst %h pc4 %h",
                             id_pc, id_inst, id_pc_plus4, exp, inst_of(exp), exp + 32'd4);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 1 after release (the DUT is still IDLE).
    task automatic do_reset();
        rst_n          = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        mem_cnt        = 0;
        mem_left       = 0;
        mem_lat        = 0;
        sb_pc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_pc.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (sb_pc.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d deliveries outstanding, expected 0", name, sb_pc.size());
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_inst !== NOP ||
            id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL %s: req %b valid %b inst %h pc %h pc4 %h, expected 0 0 %h 0 4",
                     name, imem_req, id_valid, id_inst, id_pc, id_pc_plus4, NOP);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_vals("reset_vals");
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle1_req: got %b, expected 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_req: req %b addr %h, expected 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        do_reset();
        mem_lat  = 0;
        mem_left = 6;
        for (int i = 0; i < 6; i++) sb_pc.push_back(32'(4 * i));
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL basic_addr%0d: req %b addr %h, expected 1 %h", i, imem_req, imem_addr, 32'(4 * i));
            end
            checks++;
            if (id_valid !== (i >= 1)) begin
                errors++;
                $display("FAIL basic_valid%0d: got %b, expected %b", i, id_valid, (i >= 1));
            end
            tick();
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h14) begin
            errors++;
            $display("FAIL basic_last: valid %b pc %h, expected 1 00000014", id_valid, id_pc);
        end
        drain("basic", 10);
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 32'd6) begin
            errors++;
            $display("FAIL basic_perf_fetch: got %0d, expected 6", perf_fetch_cnt);
        end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        mem_lat  = 0;
        mem_left = 2;
        id_stall = 1'b1;
        sb_pc.push_back(32'h0);
        sb_pc.push_back(32'h4);
        tick();
        tick();
        for (int k = 3; k <= 5; k++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== inst_of(32'h0)) begin
                errors++;
                $display("FAIL stall_hold_c%0d: valid %b pc %h inst %h, expected 1 0 %h",
                         k, id_valid, id_pc, id_inst, inst_of(32'h0));
            end
            if (k >= 4) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_noreq_c%0d: got %b, expected 0", k, imem_req);
                end
            end
            tick();
        end
        id_stall = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_release: req %b pc %h, expected 0 0", imem_req, id_pc);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_skid_out: valid %b pc %h req %b addr %h, expected 1 4 1 8",
                     id_valid, id_pc, imem_req, imem_addr);
        end
        drain("stall", 10);
    endtask

    task automatic test_redirect();
        do_reset();
        mem_lat  = 2;
        mem_left = 4;
        sb_pc.push_back(32'h0);
        sb_pc.push_back(32'h4);
        sb_pc.push_back(32'h100);
        while (cyc < 9) tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL redir_pending: req %b addr %h, expected 1 8", imem_req, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_target: req %b addr %h valid %b, expected 1 100 0",
                     imem_req, imem_addr, id_valid);
        end
        drain("redir", 30);
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_drop_cnt !== 32'd1) begin
            errors++;
            $display("FAIL redir_perf_drop: got %0d, expected 1", perf_drop_cnt);
        end
`endif
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        mem_lat  = 1;
        mem_left = 2;
        sb_pc.push_back(32'h40);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_rvalid: req %b addr %h valid %b, expected 1 40 0",
                     imem_req, imem_addr, id_valid);
        end
        drain("redir_rvalid", 20);
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_drop_cnt !== 32'd1) begin
            errors++;
            $display("FAIL redir_rvalid_perf_drop: got %0d, expected 1", perf_drop_cnt);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat  = 0;
        mem_left = 2;
        sb_pc.push_back(32'hFFFF_FFFC);
        sb_pc.push_back(32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: req %b, expected 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: req %b addr %h, expected 1 fffffffc", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: pc %h pc4 %h addr %h, expected fffffffc 0 0",
                     id_pc, id_pc_plus4, imem_addr);
        end
        tick();
        checks++;
        if (id_pc !== 32'h0 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL wrap_next: pc %h addr %h, expected 0 4", id_pc, imem_addr);
        end
        drain("wrap", 10);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        mem_lat  = 0;
        mem_left = 1;
        id_stall = 1'b1;
        sb_pc.push_back(32'h0);
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_pre: req %b addr %h valid %b, expected 1 4 1",
                     imem_req, imem_addr, id_valid);
        end
        rst_n = 1'b0;
        #2;
        check_reset_vals("rstwait_vals");
        do_reset();
        mem_lat  = 0;
        mem_left = 1;
        sb_pc.push_back(RST_PC);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_cycle1: req %b, expected 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL rstwait_first: req %b addr %h, expected 1 %h", imem_req, imem_addr, RST_PC);
        end
        drain("rstwait", 10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
